// File: rtl/xc_malu_wb_pkg.sv
// Shared state and selection encodings for the MALU writeback stage and the decode stage driving sel_*.
package xc_malu_wb_pkg;

  typedef enum logic [1:0] {
    XC_MALU_WB_IDLE  = 2'd0,
    XC_MALU_WB_BEAT0 = 2'd1,
    XC_MALU_WB_BEAT1 = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    XC_MALU_SEL_NONE = 2'd0,
    XC_MALU_SEL_LO   = 2'd1,
    XC_MALU_SEL_HI   = 2'd2,
    XC_MALU_SEL_WIDE = 2'd3
  } wb_sel_t;

  // Wide wins over hi, hi wins over lo.
  function automatic wb_sel_t sel_encode(input logic lo, input logic hi, input logic wide);
    if (wide)    return XC_MALU_SEL_WIDE;
    else if (hi) return XC_MALU_SEL_HI;
    else if (lo) return XC_MALU_SEL_LO;
    else         return XC_MALU_SEL_NONE;
  endfunction

endpackage

// File: rtl/xc_malu_wb.sv
// One-entry MALU writeback: captures the 64-bit result, writes 1 or 2 beats to the register file.
// First wb_valid 1 cycle after capture; beats hold until wb_ready, flush only on capture or kill.
module xc_malu_wb
  import xc_malu_wb_pkg::*;
#(
  parameter int RF_AW       = 5,
  parameter bit SUPPRESS_X0 = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             kill,
  input  logic             malu_valid,
  input  logic             malu_ready,
  input  logic [63:0]      malu_result,
  output logic             malu_flush,
  input  logic [RF_AW-1:0] rd,
  input  logic             sel_lo,
  input  logic             sel_hi,
  input  logic             sel_wide,
  output logic             wb_valid,
  output logic [RF_AW-1:0] wb_addr,
  output logic [31:0]      wb_data,
  input  logic             wb_ready,
  output logic             busy,
  output logic             done
);

  wb_state_t        state_q, state_d;
  wb_sel_t          sel_q, sel_in;
  logic [63:0]      res_q;
  logic [RF_AW-1:0] rd_q;

  logic             capture;
  logic             in_beat;
  logic             last_beat;
  logic             suppress;
  logic             retire;
  logic [RF_AW-1:0] beat_addr;
  logic [31:0]      beat_data;

  assign sel_in  = sel_encode(sel_lo, sel_hi, sel_wide);
  assign capture = (state_q == XC_MALU_WB_IDLE) && malu_valid && malu_ready && !kill;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= XC_MALU_WB_IDLE;
      res_q   <= '0;
      rd_q    <= '0;
      sel_q   <= XC_MALU_SEL_NONE;
    end else begin
      state_q <= state_d;
      if (capture) begin
        res_q <= malu_result;
        rd_q  <= rd;
        sel_q <= sel_in;
      end
    end
  end

  always_comb begin
    in_beat   = 1'b0;
    last_beat = 1'b0;
    beat_addr = '0;
    beat_data = '0;
    case (state_q)
      XC_MALU_WB_BEAT0: begin
        in_beat   = 1'b1;
        last_beat = (sel_q != XC_MALU_SEL_WIDE);
        beat_addr = (sel_q == XC_MALU_SEL_WIDE) ? {rd_q[RF_AW-1:1], 1'b0} : rd_q;
        beat_data = (sel_q == XC_MALU_SEL_HI) ? res_q[63:32] : res_q[31:0];
      end
      XC_MALU_WB_BEAT1: begin
        in_beat   = 1'b1;
        last_beat = 1'b1;
        beat_addr = {rd_q[RF_AW-1:1], 1'b1};
        beat_data = res_q[63:32];
      end
      default: ;
    endcase
  end

  // A beat aimed at x0 retires on its own without touching the write port.
  assign suppress = SUPPRESS_X0 && in_beat && (beat_addr == '0);
  assign retire   = in_beat && !kill && (wb_ready || suppress);

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = XC_MALU_WB_IDLE;
    end else begin
      case (state_q)
        XC_MALU_WB_IDLE:
          if (capture && sel_in != XC_MALU_SEL_NONE) state_d = XC_MALU_WB_BEAT0;
        XC_MALU_WB_BEAT0:
          if (retire) state_d = last_beat ? XC_MALU_WB_IDLE : XC_MALU_WB_BEAT1;
        XC_MALU_WB_BEAT1:
          if (retire) state_d = XC_MALU_WB_IDLE;
        default: state_d = XC_MALU_WB_IDLE;
      endcase
    end
  end

  assign malu_flush = capture || kill;
  assign wb_valid   = in_beat && !kill && !suppress;
  assign wb_addr    = beat_addr;
  assign wb_data    = beat_data;
  assign busy       = (state_q != XC_MALU_WB_IDLE);
  assign done       = (capture && sel_in == XC_MALU_SEL_NONE) || (retire && last_beat);

endmodule

// File: tb/tb_xc_malu_wb.sv
// Randomised bench for xc_malu_wb: MALU result model on the input side, scoreboard on wb_*.
module tb_xc_malu_wb;

  logic        clock = 1'b0;
  logic        resetn;
  logic        kill;
  logic        malu_valid;
  logic        malu_ready;
  logic [63:0] malu_result;
  logic        malu_flush;
  logic [4:0]  rd;
  logic        sel_lo, sel_hi, sel_wide;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        busy;
  logic        done;

  xc_malu_wb #(.RF_AW(5), .SUPPRESS_X0(1'b1)) dut (
    .clock(clock), .resetn(resetn), .kill(kill),
    .malu_valid(malu_valid), .malu_ready(malu_ready), .malu_result(malu_result),
    .malu_flush(malu_flush), .rd(rd), .sel_lo(sel_lo), .sel_hi(sel_hi), .sel_wide(sel_wide),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int flush_cnt = 0;
  int done0, flush0;
  int rdy_mode = 1;   // 0: ready low, 1: ready high, 2: random

  localparam int K_MUL = 0, K_MULU = 1, K_DIVU = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] malu_ref(input int kind, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    case (kind)
      K_MUL: begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return 64'(sa * sb);
      end
      K_MULU: return {32'd0, a} * {32'd0, b};
      default: return {a % b, a / b};
    endcase
  endfunction

  task automatic push_beat(input logic [4:0] addr, input logic [31:0] data, input logic last);
    beat_t b;
    if (addr != 5'd0) begin
      b.addr = addr; b.data = data; b.last = last;
      exp_q.push_back(b);
    end
  endtask

  // Register-file view of the op: which registers receive which word.
  task automatic expect_beats(input logic [4:0] r, input logic l, input logic h, input logic w,
                              input logic [63:0] res);
    if (w) begin
      push_beat(r & 5'h1e, res[31:0], 1'b0);
      push_beat(r | 5'h01, res[63:32], 1'b1);
    end else if (h) begin
      push_beat(r, res[63:32], 1'b1);
    end else if (l) begin
      push_beat(r, res[31:0], 1'b1);
    end
  endtask

  task automatic issue_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic l, input logic h, input logic w,
                          input bit do_kill, input bit push);
    logic [63:0] res;
    res = malu_ref(kind, a, b);
    @(posedge clock); #1;
    if (push) expect_beats(r, l, h, w, res);
    done0 = done_cnt;
    flush0 = flush_cnt;
    malu_valid = 1'b1; malu_ready = 1'b1; malu_result = res;
    rd = r; sel_lo = l; sel_hi = h; sel_wide = w; kill = do_kill;
    @(negedge clock);
    chk("capture_flush", malu_flush, 1'b1);
    @(posedge clock); #1;
    malu_valid = 1'b0; malu_ready = 1'b0; kill = 1'b0;
    malu_result = {$urandom, $urandom};
    rd = 5'($urandom); sel_lo = 1'b0; sel_hi = 1'b0; sel_wide = 1'b0;
  endtask

  task automatic wait_op(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock); #1;
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk({name, "_complete"}, ok, 1'b1);
    chk({name, "_done_count"}, done_cnt - done0, 1);
    chk({name, "_flush_count"}, flush_cnt - flush0, 1);
  endtask

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       wb_ready = 1'b0;
      1:       wb_ready = 1'b1;
      default: wb_ready = $urandom_range(0, 1) == 1;
    endcase
  end

  // Monitor: counts pulses, checks held beats and pops the scoreboard on each retire.
  initial begin
    bit          hold_pend = 1'b0;
    logic [4:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;
    beat_t       e;
    forever begin
      @(negedge clock);
      if (malu_flush) flush_cnt++;
      if (done) done_cnt++;
      if (!resetn || kill) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_valid", wb_valid, 1'b1);
          chk("hold_addr", wb_addr, hold_addr);
          chk("hold_data", wb_data, hold_data);
        end
        if (wb_valid) chk("x0_suppressed", wb_addr == 5'd0, 1'b0);
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_addr", wb_addr, 5'h1f);
          end else begin
            e = exp_q.pop_front();
            chk("beat_addr", wb_addr, e.addr);
            chk("beat_data", wb_data, e.data);
            chk("beat_done", done, e.last);
          end
        end
        hold_pend = wb_valid && !wb_ready;
        hold_addr = wb_addr;
        hold_data = wb_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic l, h, w;
    resetn = 1'b0; kill = 1'b0; malu_valid = 1'b0; malu_ready = 1'b0;
    malu_result = '0; rd = '0; sel_lo = 1'b0; sel_hi = 1'b0; sel_wide = 1'b0; wb_ready = 1'b0;
    #3;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_addr", wb_addr, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_flush", malu_flush, 1'b0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // mul -1*2, hi word to x5
    rdy_mode = 1;
    issue_op(K_MUL, 32'hFFFFFFFF, 32'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mul_hi_latency", wb_valid, 1'b1);
    wait_op("mul_hi");

    // mulu wide pair x6/x7
    issue_op(K_MULU, 32'h80000000, 32'd4, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_op("mulu_wide");

    // divu with write port stalled for 5 cycles
    rdy_mode = 0;
    issue_op(K_DIVU, 32'd100, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_valid", wb_valid, 1'b1);
      chk("stall_addr", wb_addr, 5'd3);
      chk("stall_data", wb_data, 32'd14);
    end
    rdy_mode = 1;
    wait_op("divu_stall");

    // lo to x0: no write, done the cycle after capture
    rdy_mode = 2;
    issue_op(K_MULU, 32'd9, 32'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("x0_done", done, 1'b1);
    chk("x0_no_valid", wb_valid, 1'b0);
    wait_op("x0_lo");

    // wide to x1: only the hi word lands in x1
    issue_op(K_MULU, 32'h12345678, 32'h9abcdef0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_op("wide_x1");

    // kill during BEAT1 with the port stalled
    rdy_mode = 0;
    issue_op(K_MULU, 32'h0000ffff, 32'h00010001, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    chk("kill_pre_valid", wb_valid, 1'b1);
    chk("kill_pre_addr", wb_addr, 5'd1);
    @(posedge clock); #1 kill = 1'b1;
    @(negedge clock);
    chk("kill_valid", wb_valid, 1'b0);
    chk("kill_done", done, 1'b0);
    chk("kill_flush", malu_flush, 1'b1);
    @(posedge clock); #1 kill = 1'b0;
    @(negedge clock);
    chk("kill_idle", busy, 1'b0);
    chk("kill_post_valid", wb_valid, 1'b0);
    chk("kill_no_done", done_cnt - done0, 0);

    // kill in the capture cycle
    rdy_mode = 1;
    issue_op(K_MUL, 32'd3, 32'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("killcap_busy", busy, 1'b0);
    @(negedge clock);
    chk("killcap_idle", busy, 1'b0);
    chk("killcap_no_done", done_cnt - done0, 0);

    // async reset while BEAT0 is stalled
    rdy_mode = 0;
    issue_op(K_DIVU, 32'd50, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    chk("rstmid_pre_valid", wb_valid, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_valid", wb_valid, 1'b0);
    chk("rstmid_addr", wb_addr, 5'd0);
    chk("rstmid_data", wb_data, 32'd0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_flush", malu_flush, 1'b0);
    @(negedge clock);
    exp_q.delete();
    @(posedge clock); #1 resetn = 1'b1;
    rdy_mode = 1;
    issue_op(K_MULU, 32'd6, 32'd7, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_op("after_reset");

    // randomised ops with random backpressure
    for (int n = 0; n < 150; n++) begin
      rdy_mode = $urandom_range(1, 2);
      kind = $urandom_range(0, 2);
      {l, h, w} = 3'($urandom);
      issue_op(kind, $urandom, $urandom_range(1, 32'hFFFF), 5'($urandom), l, h, w, 1'b0, 1'b1);
      wait_op("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
